// File: rtl/main_control_fsm_pkg.sv
// Shared definitions for the multicycle main control FSM and the ALU control
// stage: instruction opcodes, ALU operation codes and the controller state set.
package main_control_fsm_pkg;

  // Instruction opcodes (instruction bits [31:26])
  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  // ALU operation codes; RTYPE hands the choice to the funct decoder
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SUB   = 3'b101;
  localparam logic [2:0] ALU_RTYPE = 3'b111;

  // Controller states; FETCH is encoded as zero so the reset value reads as 0
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEM_ADDR = 4'd2,
    MEM_RD   = 4'd3,
    MEM_WB   = 4'd4,
    MEM_WR   = 4'd5,
    R_EXEC   = 4'd6,
    R_WB     = 4'd7,
    I_EXEC   = 4'd8,
    I_WB     = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_e;

endpackage

// File: rtl/main_control_fsm.sv
// Multicycle MIPS-style main control FSM. One state register, a captured copy
// of the opcode taken in DECODE, and a combinational next-state/output decode.
// All control outputs are held at 0 while rst_n is low, so no write strobe or
// memory read can be seen during reset even though FETCH normally reads memory.
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       alu_src_a,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_source,
  output logic       illegal_op,
  output logic [3:0] state_dbg
);

  state_e     r_state;
  state_e     w_next;
  logic [5:0] r_opcode;

  assign state_dbg = r_state;

  // State register; reset forces FETCH immediately, independent of clk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  // Opcode is captured as it is decoded so later states do not depend on the
  // input staying stable
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opcode <= 6'd0;
    end else if (r_state == DECODE) begin
      r_opcode <= opcode;
    end
  end

  // Next-state and control output decode; everything defaults to 0
  always_comb begin
    w_next     = r_state;
    alu_op     = ALU_ADD;
    pc_write   = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    i_or_d     = 1'b0;
    alu_src_a  = 1'b0;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    alu_src_b  = 2'b00;
    pc_source  = 2'b00;
    illegal_op = 1'b0;

    case (r_state)
      FETCH: begin
        mem_read  = 1'b1;
        alu_src_b = 2'b01;
        alu_op    = ALU_ADD;
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          w_next   = DECODE;
        end
      end
      DECODE: begin
        alu_src_b = 2'b11;
        alu_op    = ALU_ADD;
        case (opcode)
          OP_LW, OP_SW:    w_next = MEM_ADDR;
          OP_R:            w_next = R_EXEC;
          OP_ADDI, OP_ORI: w_next = I_EXEC;
          OP_BEQ:          w_next = BRANCH;
          OP_J:            w_next = JUMP;
          default: begin
            illegal_op = 1'b1;
            w_next     = FETCH;
          end
        endcase
      end
      MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = ALU_ADD;
        w_next    = (r_opcode == OP_SW) ? MEM_WR : MEM_RD;
      end
      MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
        if (mem_ready) w_next = MEM_WB;
      end
      MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        w_next     = FETCH;
      end
      MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
        if (mem_ready) w_next = FETCH;
      end
      R_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = ALU_RTYPE;
        w_next    = R_WB;
      end
      R_WB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
        w_next    = FETCH;
      end
      I_EXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b10;
        alu_op    = (r_opcode == OP_ORI) ? ALU_OR : ALU_ADD;
        w_next    = I_WB;
      end
      I_WB: begin
        reg_write = 1'b1;
        w_next    = FETCH;
      end
      BRANCH: begin
        alu_src_a = 1'b1;
        alu_src_b = 2'b00;
        alu_op    = ALU_SUB;
        pc_source = 2'b01;
        pc_write  = zero;
        w_next    = FETCH;
      end
      JUMP: begin
        pc_source = 2'b10;
        pc_write  = 1'b1;
        w_next    = FETCH;
      end
      default: begin
        w_next = FETCH;
      end
    endcase

    // Quiet every control output while reset is held
    if (!rst_n) begin
      alu_op     = 3'b000;
      pc_write   = 1'b0;
      ir_write   = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      i_or_d     = 1'b0;
      alu_src_a  = 1'b0;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      alu_src_b  = 2'b00;
      pc_source  = 2'b00;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_main_control_fsm.sv
// Bench for main_control_fsm. Each instruction is expanded into a list of
// expected cycles (state, inputs to drive, control word) from the per-phase
// rules of the controller, then the list is played cycle by cycle against the
// DUT and compared on the falling edge.
module tb_main_control_fsm;
  import main_control_fsm_pkg::*;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       pc_write;
    logic       ir_write;
    logic       mem_read;
    logic       mem_write;
    logic       reg_write;
    logic       i_or_d;
    logic       alu_src_a;
    logic       reg_dst;
    logic       mem_to_reg;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;
    logic       illegal_op;
  } ctl_t;

  typedef struct packed {
    logic [3:0] st;
    logic       mr;
    logic       z;
    ctl_t       c;
  } step_t;

  // ---------------- clock / reset ----------------
  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       pc_write, ir_write, mem_read, mem_write, reg_write;
  logic       i_or_d, alu_src_a, reg_dst, mem_to_reg;
  logic [1:0] alu_src_b, pc_source;
  logic       illegal_op;
  logic [3:0] state_dbg;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  main_control_fsm dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .pc_write   (pc_write),
    .ir_write   (ir_write),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .reg_write  (reg_write),
    .i_or_d     (i_or_d),
    .alu_src_a  (alu_src_a),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .alu_src_b  (alu_src_b),
    .pc_source  (pc_source),
    .illegal_op (illegal_op),
    .state_dbg  (state_dbg)
  );

  ctl_t obs;
  assign obs = '{alu_op, pc_write, ir_write, mem_read, mem_write, reg_write,
                 i_or_d, alu_src_a, reg_dst, mem_to_reg, alu_src_b, pc_source,
                 illegal_op};

  // ---------------- scoreboard ----------------
  step_t exp_q[$];
  int    n_cmp  = 0;
  int    n_fail = 0;
  int    n_memrd_seen;

  task automatic check_state(input string tag, input logic [3:0] exp_st);
    n_cmp++;
    assert (state_dbg === exp_st)
    else begin
      n_fail++;
      $error("FAIL %s state: got %0d want %0d", tag, state_dbg, exp_st);
    end
  endtask

  task automatic check_ctl(input string tag, input ctl_t exp_c);
    n_cmp++;
    assert (obs === exp_c)
    else begin
      n_fail++;
      $error("FAIL %s ctl: got %h want %h (op=%b)", tag, obs, exp_c, opcode);
    end
  endtask

  // ---------------- reference model ----------------
  task automatic push(input state_e s, input logic mr, input logic z, input ctl_t c);
    step_t t;
    t.st = s;
    t.mr = mr;
    t.z  = z;
    t.c  = c;
    exp_q.push_back(t);
  endtask

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycles
  task automatic add_instr(input logic [5:0] op, input logic z, input int fstall,
                           input int mstall);
    ctl_t c;
    bit   known;
    known = op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
    // instruction fetch, possibly waiting on memory
    c = '0;
    c.mem_read  = 1'b1;
    c.alu_src_b = 2'b01;
    c.alu_op    = ALU_ADD;
    for (int i = 0; i < fstall; i++) push(FETCH, 1'b0, rbit(), c);
    c.ir_write = 1'b1;
    c.pc_write = 1'b1;
    push(FETCH, 1'b1, rbit(), c);
    // decode / branch target
    c = '0;
    c.alu_src_b  = 2'b11;
    c.alu_op     = ALU_ADD;
    c.illegal_op = !known;
    push(DECODE, rbit(), rbit(), c);
    if (op == OP_LW || op == OP_SW) begin
      c = '0;
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      c.alu_op    = ALU_ADD;
      push(MEM_ADDR, rbit(), rbit(), c);
      c = '0;
      c.i_or_d = 1'b1;
      if (op == OP_LW) begin
        c.mem_read = 1'b1;
        for (int i = 0; i < mstall; i++) push(MEM_RD, 1'b0, rbit(), c);
        push(MEM_RD, 1'b1, rbit(), c);
        c = '0;
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        push(MEM_WB, rbit(), rbit(), c);
      end else begin
        c.mem_write = 1'b1;
        for (int i = 0; i < mstall; i++) push(MEM_WR, 1'b0, rbit(), c);
        push(MEM_WR, 1'b1, rbit(), c);
      end
    end else if (op == OP_R) begin
      c = '0;
      c.alu_src_a = 1'b1;
      c.alu_op    = ALU_RTYPE;
      push(R_EXEC, rbit(), rbit(), c);
      c = '0;
      c.reg_write = 1'b1;
      c.reg_dst   = 1'b1;
      push(R_WB, rbit(), rbit(), c);
    end else if (op == OP_ADDI || op == OP_ORI) begin
      c = '0;
      c.alu_src_a = 1'b1;
      c.alu_src_b = 2'b10;
      c.alu_op    = (op == OP_ORI) ? ALU_OR : ALU_ADD;
      push(I_EXEC, rbit(), rbit(), c);
      c = '0;
      c.reg_write = 1'b1;
      push(I_WB, rbit(), rbit(), c);
    end else if (op == OP_BEQ) begin
      c = '0;
      c.alu_src_a = 1'b1;
      c.alu_op    = ALU_SUB;
      c.pc_source = 2'b01;
      c.pc_write  = z;
      push(BRANCH, rbit(), z, c);
    end else if (op == OP_J) begin
      c = '0;
      c.pc_source = 2'b10;
      c.pc_write  = 1'b1;
      push(JUMP, rbit(), rbit(), c);
    end
  endtask

  // ---------------- driver ----------------
  // Called just after a rising edge; plays queued cycles. With stop_in_memrd
  // set it returns right after the second MEM_RD cycle has been checked.
  task automatic run_steps(input string tag, input bit stop_in_memrd);
    step_t t;
    n_memrd_seen = 0;
    while (exp_q.size() > 0) begin
      t = exp_q.pop_front();
      mem_ready = t.mr;
      zero      = t.z;
      @(negedge clk);
      check_state(tag, t.st);
      check_ctl(tag, t.c);
      if (stop_in_memrd && t.st == MEM_RD) begin
        n_memrd_seen++;
        if (n_memrd_seen == 2) begin
          exp_q.delete();
          return;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_instr(input string tag, input logic [5:0] op, input logic z,
                          input int fstall, input int mstall);
    opcode = op;
    add_instr(op, z, fstall, mstall);
    run_steps(tag, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] rop;
    logic [5:0] op_tab [7];
    op_tab = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ORI};
    rst_n     = 1'b0;
    opcode    = 6'd0;
    zero      = 1'b0;
    mem_ready = 1'b0;

    // reset state: FETCH with every output quiet, mem_read included
    #2;
    check_state("reset", FETCH);
    check_ctl("reset", '0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // directed instructions
    do_instr("lw",      OP_LW,   1'b0, 0, 0);
    do_instr("sw_stall", OP_SW,  1'b0, 2, 3);
    do_instr("beq_z1",  OP_BEQ,  1'b1, 0, 0);
    do_instr("beq_z0",  OP_BEQ,  1'b0, 0, 0);
    do_instr("rtype",   OP_R,    1'b0, 0, 0);
    do_instr("ori",     OP_ORI,  1'b0, 0, 0);
    do_instr("addi",    OP_ADDI, 1'b0, 1, 0);
    do_instr("jump",    OP_J,    1'b0, 0, 0);
    do_instr("illegal", 6'b111111, 1'b0, 0, 0);
    do_instr("lw_stall", OP_LW,  1'b0, 1, 2);

    // randomized instruction stream
    for (int k = 0; k < 60; k++) begin
      if ($urandom_range(0, 8) >= 7) rop = 6'($urandom_range(0, 63));
      else rop = op_tab[$urandom_range(0, 6)];
      do_instr("rand", rop, rbit(), int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)));
    end

    // reset in the middle of a stalled load read
    opcode = OP_LW;
    add_instr(OP_LW, 1'b0, 0, 4);
    run_steps("pre_rst", 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check_state("rst_mid", FETCH);
    check_ctl("rst_mid", '0);
    @(posedge clk);
    #1;
    check_state("rst_hold", FETCH);
    check_ctl("rst_hold", '0);
    mem_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // aborted load leaves no trace; the next instruction runs from FETCH
    do_instr("post_rst", OP_R, 1'b0, 0, 0);
    do_instr("post_rst_lw", OP_LW, 1'b0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/main_control_fsm.md
MAIN_CONTROL_FSM -- requirements
Module: main_control_fsm

Interface
REQ-001 Parameter none; opcode and ALU codes come from the shared package (REQ-030).
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 opcode  input  6  instruction bits [31:26], sampled in DECODE.
REQ-005 zero  input  1  ALU zero flag, used in BRANCH.
REQ-006 mem_ready  input  1  memory handshake; access completes in the cycle it is high.
REQ-007 alu_op  output  3  operation code driven to the ALU control stage; 3'b111 selects R-type funct decode.
REQ-008 pc_write, ir_write, mem_read, mem_write, reg_write  output  1 each  write/access strobes.
REQ-009 i_or_d, alu_src_a, reg_dst, mem_to_reg  output  1 each  mux selects.
REQ-010 alu_src_b, pc_source  output  2 each  mux selects.
REQ-011 illegal_op  output  1  one-cycle pulse on an unsupported opcode.
REQ-012 state_dbg  output  4  current state encoding.

Function
REQ-013 Supported opcodes: R 000000, LW 100011, SW 101011, BEQ 000100, J 000010, ADDI 001000, ORI 001101.
REQ-014 ALU codes: ADD 3'b000, OR 3'b001, SUB 3'b101, RTYPE 3'b111.
REQ-015 States: FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
REQ-016 FETCH: mem_read=1, i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=ADD, pc_source=00; ir_write and pc_write =1 only when mem_ready=1; stays in FETCH while mem_ready=0, else goes to DECODE.
REQ-017 DECODE: alu_src_a=0, alu_src_b=11, alu_op=ADD (branch target); next state by opcode: LW/SW->MEM_ADDR, R->R_EXEC, ADDI/ORI->I_EXEC, BEQ->BRANCH, J->JUMP, other->FETCH with illegal_op=1 this cycle.
REQ-018 MEM_ADDR: alu_src_a=1, alu_src_b=10, alu_op=ADD; LW->MEM_RD, SW->MEM_WR (opcode held by IR, stable).
REQ-019 MEM_RD: mem_read=1, i_or_d=1; waits while mem_ready=0; then MEM_WB.
REQ-020 MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; ->FETCH.
REQ-021 MEM_WR: mem_write=1, i_or_d=1; waits while mem_ready=0; then FETCH.
REQ-022 R_EXEC: alu_src_a=1, alu_src_b=00, alu_op=RTYPE; ->R_WB. R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; ->FETCH.
REQ-023 I_EXEC: alu_src_a=1, alu_src_b=10, alu_op=ADD for ADDI, OR for ORI; ->I_WB. I_WB: reg_write=1, reg_dst=0, mem_to_reg=0; ->FETCH.
REQ-024 BRANCH: alu_src_a=1, alu_src_b=00, alu_op=SUB, pc_source=01, pc_write=zero; ->FETCH.
REQ-025 JUMP: pc_source=10, pc_write=1; ->FETCH.
REQ-026 Outputs not listed for a state SHALL be 0; outputs are combinational from state (plus mem_ready/zero where stated); no strobe glitches into a write while rst_n low.
REQ-027 Cycle counts with mem_ready tied high: LW 5, SW 4, R 4, ADDI/ORI 4, BEQ 3, J 3, illegal 2.

Reset
REQ-028 rst_n low SHALL immediately force state FETCH and all outputs 0 (including mem_read), independent of clk.
REQ-029 Reset asserted mid-instruction aborts it; no write strobe issues; first FETCH begins on the first rising edge after rst_n deasserts.

Structure
REQ-030 Shared package holds opcode constants, ALU code constants (consumed also by alu_control) and the state enum.
REQ-031 Single module; no sub-module; one state register plus next-state and output decode.

Verification
REQ-032 Reset: rst_n low mid-MEM_RD -> state_dbg=FETCH and all strobes 0 within the same cycle; no reg_write.
REQ-033 LW opcode 100011, mem_ready=1 -> states FETCH,DECODE,MEM_ADDR,MEM_RD,MEM_WB; reg_write=1 and mem_to_reg=1 only in cycle 5.
REQ-034 BEQ with zero=1 -> pc_write=1, pc_source=01, alu_op=101 in cycle 3; repeat with zero=0 -> pc_write=0.
REQ-035 R-type -> alu_op=111 in R_EXEC; ORI 001101 -> alu_op=001 in I_EXEC; reg_dst 1 vs 0 in writeback.
REQ-036 Stall: SW with mem_ready low for 3 cycles in MEM_WR -> mem_write held 4 cycles, then FETCH; FETCH stall holds ir_write=0.
REQ-037 Opcode 111111 -> illegal_op=1 for one cycle in DECODE, next state FETCH, no write strobes.
